// File: rtl/sequential_divide.sv
// sequential_divide: iterative restoring divider, one quotient bit per clock.
// Unsigned N-bit dividend / M-bit divisor -> N-bit quotient, M-bit remainder,
// with a start/busy/done handshake. Results are held until the next operation.
// Optional build macro: DIVIDE_ZERO_CHECK_EN. When it is defined, a zero
// divisor finishes in one cycle with err=1. When it is undefined, a zero divisor
// runs the full N cycles and err stays 0.
module sequential_divide #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         err
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   q_q, q_d;
  logic [M-1:0]   d_q, d_d;
  // The partial remainder's top bit is always 0 after an iteration, because
  // R < D. Only the low M bits are kept, and they feed the next trial value.
  logic [M-1:0]   r_q, r_d;
  logic [CW-1:0]  count_q, count_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N-1:0]   quotient_q, quotient_d;
  logic [M-1:0]   remainder_q, remainder_d;
  logic           err_q, err_d;

  logic [M:0]     t;
  logic           ge;
  logic [N-1:0]   q_iter;
  logic [M-1:0]   r_iter;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      d_q         <= d_d;
      r_q         <= r_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      err_q       <= err_d;
    end
  end

  // Next-state, one restoring iteration, and output register updates
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    d_d         = d_q;
    r_d         = r_q;
    count_d     = count_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    err_d       = err_q;

    t      = {r_q, q_q[N-1]};
    ge     = (t >= {1'b0, d_q});
    q_iter = {q_q[N-2:0], ge};
    r_iter = ge ? M'(t - {1'b0, d_q}) : t[M-1:0];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          q_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          count_d = CW'(N - 1);
`ifdef DIVIDE_ZERO_CHECK_EN
          if (divisor == '0) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend[M-1:0];
            err_d       = 1'b1;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end
`else
          state_d = S_RUN;
          busy_d  = 1'b1;
`endif
        end
      end
      S_RUN: begin
        q_d     = q_iter;
        r_d     = r_iter;
        count_d = count_q - CW'(1);
        if (count_q == '0) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          quotient_d  = q_iter;
          remainder_d = r_iter;
          err_d       = 1'b0;
        end else begin
          busy_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sequential_divide.sv
// Testbench for sequential_divide. It runs a table of known vectors, the
// multi-cycle corner sequences, an exhaustive sweep of nonzero divisors, and
// random operands checked against an arithmetic reference model.
module tb_sequential_divide;

  localparam int unsigned N = 8;
  localparam int unsigned M = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
  logic         err;

  int checks = 0;
  int errors = 0;

  sequential_divide #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  always #5 clk = ~clk;

`ifdef DIVIDE_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] a;
    logic [M-1:0] b;
    logic [N-1:0] q;
    logic [M-1:0] r;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer division, with the zero-divisor result defined as all ones / low bits
  task automatic ref_model(input logic [N-1:0] a, input logic [M-1:0] b,
                           output logic [N-1:0] q, output logic [M-1:0] r);
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) begin
      q = '1;
      r = a[M-1:0];
    end else begin
      q = N'(ai / bi);
      r = M'(ai % bi);
    end
  endtask

  // Pulse start for one cycle, scramble the operands after accept, then wait for done
  task automatic do_div(input logic [N-1:0] a, input logic [M-1:0] b,
                        input logic [N-1:0] eq, input logic [M-1:0] er);
    int cyc, bc, exp_lat, exp_busy;
    logic ee;
    ee       = (ZCHK && b == '0);
    exp_lat  = ee ? 1 : N + 1;
    exp_busy = ee ? 0 : N;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = M'($urandom);
    cyc = 1;
    bc  = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, exp_lat);
    check("busy_cycles", bc, exp_busy);
    check("busy_at_done", busy, 0);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("err", err, ee);
  endtask

  vec_t vecs[8];

  initial begin
    logic [N-1:0] mq, ra;
    logic [M-1:0] mr, rb;
    int cyc, pulses;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    // Known vectors with hand-computed results
    vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4};
    vecs[1] = '{8'd255, 4'd1,  8'd255, 4'd0};
    vecs[2] = '{8'd5,   4'd9,  8'd0,   4'd5};
    vecs[3] = '{8'hA6,  4'd0,  8'hFF,  4'd6};
    vecs[4] = '{8'd15,  4'd15, 8'd1,   4'd0};
    vecs[5] = '{8'd0,   4'd3,  8'd0,   4'd0};
    vecs[6] = '{8'd255, 4'd15, 8'd17,  4'd0};
    vecs[7] = '{8'd100, 4'd3,  8'd33,  4'd1};
    for (int i = 0; i < 8; i++) begin
      do_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
    end

    // Back-to-back: start held high across done -> one idle cycle -> new run
    @(negedge clk);
    dividend = 8'd255;
    divisor  = 4'd1;
    start    = 1'b1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_first_lat", cyc, N + 1);
    check("b2b_first_q", quotient, 255);
    check("b2b_first_r", remainder, 0);
    dividend = 8'd5;
    divisor  = 4'd9;
    @(negedge clk);
    check("b2b_idle_busy", busy, 0);
    check("b2b_idle_done", done, 0);
    check("b2b_idle_q_held", quotient, 255);
    @(negedge clk);
    check("b2b_second_busy", busy, 1);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_second_lat", cyc, N + 1);
    check("b2b_second_q", quotient, 0);
    check("b2b_second_r", remainder, 5);

    // Reset on the third busy cycle aborts the operation with no done pulse
    do_div(8'd200, 4'd7, 8'd28, 4'd4);
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 4'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("abort_no_done", pulses, 0);
    do_div(8'd100, 4'd3, 8'd33, 4'd1);

    // A start pulse during RUN is ignored
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 4'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    dividend = 8'd9;
    divisor  = 4'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 4;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("ignore_lat", cyc, N + 1);
    check("ignore_q", quotient, 10);
    check("ignore_r", remainder, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ignore_idle_busy", busy, 0);
      check("ignore_hold_q", quotient, 10);
      check("ignore_hold_r", remainder, 0);
    end

    // Exhaustive sweep over every nonzero divisor
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        do_div(N'(a), M'(b), N'(a / b), M'(a % b));
      end
    end

    // Random operands, including zero divisors, checked against the reference model
    for (int i = 0; i < 150; i++) begin
      ra = N'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? '0 : M'($urandom);
      ref_model(ra, rb, mq, mr);
      do_div(ra, rb, mq, mr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
